// File: rtl/audio_track_sequencer.sv
// Multi-track audio sequencer: one looping background track plus priority-arbitrated
// effect tracks, sharing one sample store with a fixed one-cycle read latency.
module audio_track_sequencer #(
    parameter int NUM_TRACKS = 5,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int BG_TRACK   = 0,
    parameter int TRK_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic                         bg_en,
    input  logic [NUM_TRACKS-1:0]        trig,
    input  logic                         stop,
    input  logic                         mute,
    input  logic [NUM_TRACKS*ADDR_W-1:0] trk_depth,
    input  logic [NUM_TRACKS-1:0]        trk_loop,
    output logic [TRK_W-1:0]             rom_track,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic [DATA_W-1:0]            sample,
    output logic                         sample_valid,
    output logic [TRK_W-1:0]             cur_track,
    output logic                         busy,
    output logic                         fx_done
);

    typedef enum logic [1:0] {IDLE, PLAY_BG, PLAY_FX} state_t;

    localparam logic [TRK_W-1:0] BG_IDX = TRK_W'(BG_TRACK);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt, saved_bg_addr, saved_nxt;
    logic [TRK_W-1:0]  trk_nxt;
    logic              fx_done_nxt;
    logic [ADDR_W-1:0] depth [NUM_TRACKS];
    logic [ADDR_W-1:0] depth_cur;
    logic              win_vld, trig_ok, bg_ok, at_end, cur_loop;
    logic [TRK_W-1:0]  win_idx;
    logic              tick_d, play_d;
    logic [DATA_W-1:0] sample_q, sample_live;

    // Ascending scan so the highest qualifying index overwrites lower ones.
    always_comb begin
        win_vld = 1'b0;
        win_idx = BG_IDX;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            depth[i] = trk_depth[i*ADDR_W +: ADDR_W];
            if (i != BG_TRACK && trig[i] && depth[i] != '0) begin
                win_vld = 1'b1;
                win_idx = TRK_W'(i);
            end
        end
    end

    assign depth_cur = depth[rom_track];
    assign cur_loop  = trk_loop[rom_track];
    // >= rather than == so a depth shrunk below the current address ends the track.
    assign at_end    = rom_addr >= (depth_cur - 1'b1);
    assign trig_ok   = win_vld && (state != PLAY_FX || win_idx >= rom_track);
    assign bg_ok     = bg_en && depth[BG_TRACK] != '0;

    always_comb begin
        state_nxt   = state;
        addr_nxt    = rom_addr;
        trk_nxt     = rom_track;
        saved_nxt   = saved_bg_addr;
        fx_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (trig_ok) begin
                    state_nxt = PLAY_FX;
                    trk_nxt   = win_idx;
                    addr_nxt  = '0;
                end else if (bg_ok) begin
                    state_nxt = PLAY_BG;
                    trk_nxt   = BG_IDX;
                    addr_nxt  = '0;
                end
            end
            PLAY_BG: begin
                if (trig_ok) begin
                    state_nxt = PLAY_FX;
                    saved_nxt = rom_addr;
                    trk_nxt   = win_idx;
                    addr_nxt  = '0;
                end else if (!bg_en) begin
                    state_nxt = IDLE;
                    saved_nxt = '0;
                    trk_nxt   = BG_IDX;
                    addr_nxt  = '0;
                end else if (sample_tick) begin
                    addr_nxt = at_end ? '0 : rom_addr + 1'b1;
                end
            end
            PLAY_FX: begin
                if (trig_ok) begin
                    trk_nxt  = win_idx;
                    addr_nxt = '0;
                end else if (stop || (sample_tick && at_end && !cur_loop)) begin
                    fx_done_nxt = !stop;
                    trk_nxt     = BG_IDX;
                    if (bg_ok) begin
                        state_nxt = PLAY_BG;
                        addr_nxt  = saved_bg_addr;
                    end else begin
                        state_nxt = IDLE;
                        addr_nxt  = '0;
                    end
                end else if (sample_tick) begin
                    addr_nxt = at_end ? '0 : rom_addr + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                trk_nxt   = BG_IDX;
                addr_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rom_addr      <= '0;
            rom_track     <= BG_IDX;
            saved_bg_addr <= '0;
            fx_done       <= 1'b0;
        end else begin
            state         <= state_nxt;
            rom_addr      <= addr_nxt;
            rom_track     <= trk_nxt;
            saved_bg_addr <= saved_nxt;
            fx_done       <= fx_done_nxt;
        end
    end

    // Store returns data the cycle after a tick; emit it live then hold it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d   <= 1'b0;
            play_d   <= 1'b0;
            sample_q <= '0;
        end else begin
            tick_d <= sample_tick;
            play_d <= state != IDLE;
            if (tick_d) sample_q <= sample_live;
        end
    end

    assign sample_live  = (mute || !play_d) ? '0 : rom_data;
    assign sample       = tick_d ? sample_live : sample_q;
    assign sample_valid = tick_d;
    assign cur_track    = rom_track;
    assign busy         = state != IDLE;

endmodule
